// File: rtl/ctech_lib_hs_rx.sv
// 4-phase req/ack receiver: sync req_async, capture data, offer on vld/rdy; vld SYNC_STAGES+1 edges after req, ack on accept edge.
// Backpressure: payload held in vld until rdy; ack withheld meanwhile. Optional parity via CTECH_LIB_HS_RX_PARITY_EN.
module ctech_lib_hs_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_async,
  input  logic [WIDTH-1:0] data_async,
`ifdef CTECH_LIB_HS_RX_PARITY_EN
  input  logic             par_async,
  output logic             par_err,
`endif
  output logic             ack,
  output logic             vld,
  output logic [WIDTH-1:0] data,
  input  logic             rdy,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             req_s;
  logic             ack_q, ack_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             perr_q, perr_d;

  // req_async feeds only the first synchronizer stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], req_async};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

`ifdef CTECH_LIB_HS_RX_PARITY_EN
  logic par_err_q, par_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end

  // even parity: XOR of payload and parity bit must be 0 at capture
  always_comb begin
    par_err_d = par_err_q;
    if (state_q == IDLE && req_s && ((^data_async) ^ par_async))
      par_err_d = 1'b1;
  end

  assign par_err = par_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    vld_d   = vld_q;
    data_d  = data_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          data_d  = data_async;
          vld_d   = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        // early withdrawal is flagged but the transfer still completes
        if (!req_s) perr_d = 1'b1;
        if (rdy) begin
          vld_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign ack       = ack_q;
  assign vld       = vld_q;
  assign data      = data_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_ctech_lib_hs_rx.sv
// Bench for ctech_lib_hs_rx: vector table of timed transfers, corner-case sequences, delivery scoreboard.
module tb_ctech_lib_hs_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_async;
  logic [7:0] data_async;
  logic       ack;
  logic       vld;
  logic [7:0] data;
  logic       rdy;
  logic       proto_err;
`ifdef CTECH_LIB_HS_RX_PARITY_EN
  logic       par_async;
  logic       par_err;
`endif

  int total = 0;
  int bad   = 0;
  int pushes = 0;
  int pops   = 0;
  logic [7:0] sb[$];
  bit b2b_done;

  always #5 clk = ~clk;

  ctech_lib_hs_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_async  (req_async),
    .data_async (data_async),
`ifdef CTECH_LIB_HS_RX_PARITY_EN
    .par_async  (par_async),
    .par_err    (par_err),
`endif
    .ack        (ack),
    .vld        (vld),
    .data       (data),
    .rdy        (rdy),
    .proto_err  (proto_err)
  );

  typedef struct {
    logic [7:0] din;
    int         rdy_wait;
    logic [7:0] exp_data;
    int         exp_vld_edges;
    int         exp_ack_edges;
    int         exp_drop_edges;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", nm, act, exp);
    end
  endtask

  // count rising edges until the selected output reaches val; -1 if the budget runs out
  task automatic wait_for(input bit sel_ack, input logic val, output int n);
    n = -1;
    for (int i = 1; i <= 60 && n < 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ((sel_ack ? ack : vld) === val) n = i;
    end
  endtask

  task automatic push_exp(input logic [7:0] d);
    sb.push_back(d);
    pushes++;
  endtask

  task automatic xfer(input vec_t v);
    int n;
    int stable;
    rdy        = (v.rdy_wait == 0);
    req_async  = 1'b1;
    data_async = v.din;
    push_exp(v.din);
    wait_for(1'b0, 1'b1, n);
    chk("vld_latency", n, v.exp_vld_edges);
    chk("vld_data", data, v.exp_data);
    if (v.rdy_wait > 0) begin
      stable = 0;
      repeat (v.rdy_wait) begin
        @(posedge clk);
        @(negedge clk);
        if (vld === 1'b1 && data === v.exp_data && ack === 1'b0) stable++;
      end
      chk("backpressure_hold", stable, v.rdy_wait);
      @(posedge clk);
      #1 rdy = 1'b1;
    end
    wait_for(1'b1, 1'b1, n);
    chk("ack_latency", n, v.exp_ack_edges);
    chk("vld_clear_on_accept", vld, 1'b0);
    @(posedge clk);
    #1;
    rdy       = 1'b0;
    req_async = 1'b0;
    wait_for(1'b1, 1'b0, n);
    chk("ack_fall_latency", n, v.exp_drop_edges);
    @(posedge clk);
    #1;
  endtask

  // consumer side: every accept must match the oldest outstanding payload
  always @(negedge clk) begin
    if (rst === 1'b0 && vld === 1'b1 && rdy === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected got=0x%0h want=none", data);
      end else begin
        chk("sb_data", data, sb.pop_front());
      end
      pops++;
    end
  end

  initial begin
    int n;
    tbl[0] = '{8'h3C, 0,  8'h3C, 3, 1, 3};
    tbl[1] = '{8'h5A, 10, 8'h5A, 3, 1, 3};
    tbl[2] = '{8'hFF, 1,  8'hFF, 3, 1, 3};
    tbl[3] = '{8'h00, 3,  8'h00, 3, 1, 3};

    rst        = 1'b1;
    req_async  = 1'b0;
    data_async = 8'h00;
    rdy        = 1'b0;
    b2b_done   = 1'b0;
`ifdef CTECH_LIB_HS_RX_PARITY_EN
    par_async  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ack", ack, 1'b0);
    chk("reset_vld", vld, 1'b0);
    chk("reset_data", data, 8'h00);
    chk("reset_proto_err", proto_err, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) xfer(tbl[i]);

    // sender withdraws request while payload is still waiting for the consumer
    rdy        = 1'b0;
    req_async  = 1'b1;
    data_async = 8'h77;
    push_exp(8'h77);
    wait_for(1'b0, 1'b1, n);
    chk("viol_vld_latency", n, 3);
    @(posedge clk);
    #1 req_async = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("viol_proto_err", proto_err, 1'b1);
    chk("viol_vld_held", vld, 1'b1);
    chk("viol_ack_low", ack, 1'b0);
    @(posedge clk);
    #1 rdy = 1'b1;
    wait_for(1'b1, 1'b1, n);
    chk("viol_ack_latency", n, 1);
    @(posedge clk);
    @(negedge clk);
    chk("viol_ack_pulse_end", ack, 1'b0);
    chk("viol_idle_vld", vld, 1'b0);
    @(posedge clk);
    #1 rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("viol_sticky", proto_err, 1'b1);

    // reset mid-VALID, then redelivery of the still-requested payload
    @(posedge clk);
    #1;
    req_async  = 1'b1;
    data_async = 8'hA5;
    push_exp(8'hA5);
    wait_for(1'b0, 1'b1, n);
    chk("rst_pre_data", data, 8'hA5);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ack", ack, 1'b0);
    chk("midrst_vld", vld, 1'b0);
    chk("midrst_data", data, 8'h00);
    chk("midrst_proto_err", proto_err, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_for(1'b0, 1'b1, n);
    chk("redeliver_latency", n, 3);
    chk("redeliver_data", data, 8'hA5);
    @(posedge clk);
    #1 rdy = 1'b1;
    wait_for(1'b1, 1'b1, n);
    chk("redeliver_ack", n, 1);
    @(posedge clk);
    #1;
    rdy       = 1'b0;
    req_async = 1'b0;
    wait_for(1'b1, 1'b0, n);
    chk("redeliver_ack_fall", n, 3);
    @(posedge clk);
    #1;

    // back-to-back payloads 0..15 against a randomly stalling consumer
    fork
      begin
        int m;
        for (int i = 0; i < 16; i++) begin
          req_async  = 1'b1;
          data_async = 8'(i);
          push_exp(8'(i));
          wait_for(1'b1, 1'b1, m);
          chk("b2b_ack_seen", (m > 0), 1'b1);
          @(posedge clk);
          #1 req_async = 1'b0;
          wait_for(1'b1, 1'b0, m);
          chk("b2b_ack_drop", (m > 0), 1'b1);
          @(posedge clk);
          #1;
        end
        b2b_done = 1'b1;
      end
      begin
        while (!b2b_done) begin
          @(posedge clk);
          #1 rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    rdy = 1'b0;

`ifdef CTECH_LIB_HS_RX_PARITY_EN
    par_async = 1'b0;
    xfer('{8'h01, 0, 8'h01, 3, 1, 3});
    chk("parity_err_set", par_err, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    par_async = 1'b1;
    xfer('{8'h01, 0, 8'h01, 3, 1, 3});
    chk("parity_err_clear", par_err, 1'b0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("sb_count", pops, pushes);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ctech_lib_hs_rx.md
# ctech_lib_hs_rx

Responder (receive) end of a 4-phase req/ack data-crossing handshake. A sender in a foreign clock domain drives `req_async` high with `data_async` held stable. This block synchronizes `req_async` into `clk`, captures the data into a one-entry output register and presents it to a local consumer with a valid/ready handshake. It returns `ack` only after the consumer accepts, then completes the return-to-zero phase. It is the ctech-library primitive placed on the receiving side of every slow control/status bus crossing.

## Interface
Parameters:
- `WIDTH`, 8, payload width in bits (≥1).
- `SYNC_STAGES`, 2, flop stages in the `req_async` synchronizer (≥2).

Ports:
- `clk`  in  1  receive-domain clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_async`  in  1  sender request, asynchronous to `clk`.
- `data_async`  in  WIDTH  sender payload; stable while `req_async`=1.
- `ack`  out  1  acknowledge to sender, registered.
- `vld`  out  1  payload valid to consumer, registered.
- `data`  out  WIDTH  captured payload, registered.
- `rdy`  in  1  consumer ready.
- `proto_err`  out  1  sticky protocol-violation flag.

## Operation
- `req_s` is the synchronizer output. `req_async` is sampled by the first stage only; no other logic touches it.
- FSM states:
  - IDLE: `ack`=0, `vld`=0. When `req_s`=1, capture `data_async` into `data`, set `vld`=1 and go to VALID.
  - VALID: hold `data` and `vld`. On an edge with `rdy`=1, clear `vld`, set `ack`=1 and go to ACK.
  - ACK: hold `ack`=1. On an edge with `req_s`=0, clear `ack` and go to IDLE.
- `data` holds its last captured value outside VALID; it is never cleared except by reset.
- `proto_err` is set when `req_s`=0 in VALID, which means the sender withdrew its request before `ack`. The FSM ignores the withdrawal and still delivers and acks. The flag is cleared only by `rst`.
- `rdy` is ignored outside VALID.
- Reset mid-operation: all state is cleared immediately. A request still high after reset is treated as a new request, so duplicate delivery of that payload is possible and allowed.

## Timing
- Reset values: `ack`=0, `vld`=0, `data`=0, `proto_err`=0, state IDLE, all synchronizer flops 0.
- `req_async` rise to `req_s`=1: SYNC_STAGES edges (±1 for metastability).
- `req_s`=1 to `vld`=1: 1 edge. `data` is valid in the same cycle as `vld`.
- Accept (edge with `vld`&`rdy`) to `vld`=0 and `ack`=1: the same edge.
- `req_async` fall to `ack`=0: SYNC_STAGES+1 edges (±1).
- `ack` is high for at least 1 cycle.
- Minimum IDLE dwell is 1 cycle. A new `req_s`=1 seen in IDLE starts the next transfer on the following edge.
- Full cycle with `rdy` tied high: 2·SYNC_STAGES+3 `clk` cycles, not counting sender latency.

## Configuration
- `CTECH_LIB_HS_RX_PARITY_EN`
  - Defined: adds input `par_async` (1 bit, even parity over `data_async`), captured alongside the data. Computed parity is checked at capture. On mismatch, sticky output `par_err` is set, cleared only by `rst`. Data is still delivered and acked.
  - Undefined: no `par_async` or `par_err` ports and no parity logic; behaviour otherwise identical.

## Test plan
- Reset: assert `rst` mid-VALID with `data`=8'hA5 → next sample shows `ack`=0, `vld`=0, `data`=0, `proto_err`=0. Deassert `rst` with `req_async` still 1 → redelivery of the same payload.
- Basic transfer (SYNC_STAGES=2, `rdy`=1): `req_async`↑ with `data_async`=8'h3C → `vld`=1 and `data`=8'h3C after 3 edges, `ack`↑ 1 edge later. Drop `req` → `ack`↓ after 3 edges; total 7 cycles.
- Backpressure: hold `rdy`=0 for 10 cycles → `vld` and `data` stable for 10 cycles, `ack` stays 0. Raise `rdy` → `ack`=1 on the accept edge.
- Back-to-back: 16 transfers with payloads 0..15 and random `rdy` → consumer sees exactly 0..15 in order, with no drops or duplicates.
- Protocol violation: drop `req_async` while in VALID → `proto_err`=1, payload still delivered, `ack` pulses for 1 cycle, FSM returns to IDLE.
- Parity (macro defined): `data_async`=8'h01 with `par_async`=0 → `par_err`=1 and delivery still occurs. With `par_async`=1 → `par_err` stays 0.
